// File: rtl/nibble_loader_pkg.sv
// Shared widths, FSM state type and nibble-shift helper for the nibble loader.
package nibble_loader_pkg;

  localparam int unsigned NIB_W       = 4;
  localparam int unsigned WORD_NIBS   = 4;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = $clog2(WORD_NIBS);
  localparam int unsigned PART_W      = WORD_W - NIB_W;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Earlier nibbles move toward the MSB end as new ones arrive.
  function automatic logic [PART_W-1:0] shift_in(input logic [PART_W-1:0] part,
                                                 input logic [NIB_W-1:0]  nib);
    return {part[PART_W-NIB_W-1:0], nib};
  endfunction

endpackage

// File: rtl/nibble_loader_if.sv
// Pin-side nibble inputs plus the word/valid/ready consumer handshake.
interface nibble_loader_if;
  import nibble_loader_pkg::*;

  logic [NIB_W-1:0]  din;
  logic              stb;
  logic              sync;
  logic [WORD_W-1:0] word;
  logic              valid;
  logic              ready;
  logic              ovf;
  logic [CNT_W-1:0]  cnt;

  modport master (output din, stb, sync, ready, input word, valid, ovf, cnt);
  modport slave  (input din, stb, sync, ready, output word, valid, ovf, cnt);
endinterface

// File: rtl/nibble_loader_pin_sync.sv
// Parameterized-width multi-flop synchronizer with synchronous active-low reset.
module pin_sync
  import nibble_loader_pkg::*;
#(
  parameter int unsigned W      = 1,
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(STAGES); i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/nibble_loader.sv
// Assembles four strobed pin nibbles into a 16-bit word with a valid/ready output.
module nibble_loader
  import nibble_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  nibble_loader_if.slave  bus
);

  logic             stb_s;
  logic             sync_s;
  logic [NIB_W-1:0] din_s;

  pin_sync #(.W(1))     u_stb  (.clk(clk), .rst(rst), .d(bus.stb),  .q(stb_s));
  pin_sync #(.W(1))     u_sync (.clk(clk), .rst(rst), .d(bus.sync), .q(sync_s));
  pin_sync #(.W(NIB_W)) u_din  (.clk(clk), .rst(rst), .d(bus.din),  .q(din_s));

  localparam logic [1:0] ARM_FILLED = 2'd2;
  localparam logic [1:0] ARM_LIVE   = 2'd3;

  logic       stb_d;
  logic [1:0] arm;
  logic       nib_ev;

  // Edge detection only goes live once the synchronizer has carried a real low
  // STB sample after reset, so STB held high through reset release is ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stb_d <= 1'b0;
      arm   <= 2'd0;
    end else begin
      stb_d <= stb_s;
      if (arm < ARM_FILLED)                     arm <= 2'(arm + 2'd1);
      else if (arm == ARM_FILLED && !stb_s)     arm <= ARM_LIVE;
    end
  end

  assign nib_ev = stb_s & ~stb_d & (arm == ARM_LIVE);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [PART_W-1:0] part, part_nx;
  logic [WORD_W-1:0] word, word_nx;
  logic              ovf, ovf_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= COLLECT;
      cnt   <= '0;
      part  <= '0;
      word  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      part  <= part_nx;
      word  <= word_nx;
      ovf   <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    part_nx  = part;
    word_nx  = word;
    ovf_nx   = ovf;

    if (state == HOLD && bus.ready) state_nx = COLLECT;

    // Resync wins over a coincident nibble event.
    if (sync_s) begin
      cnt_nx  = '0;
      part_nx = '0;
    end else if (nib_ev) begin
      cnt_nx = CNT_W'(cnt + 1'b1);
      if (cnt == CNT_W'(WORD_NIBS - 1)) begin
        part_nx = '0;
        if (state == COLLECT || bus.ready) begin
          word_nx  = {part, din_s};
          state_nx = HOLD;
        end else begin
          ovf_nx = 1'b1;
        end
      end else begin
        part_nx = shift_in(part, din_s);
      end
    end
  end

  assign bus.word  = word;
  assign bus.valid = (state == HOLD);
  assign bus.ovf   = ovf;
  assign bus.cnt   = cnt;

endmodule

// File: tb/tb_nibble_loader.sv
// Randomized and directed bench for nibble_loader against a pin-sample reference model.
module tb_nibble_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nibble_loader_if bus ();
  nibble_loader u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    bit       stb;
    bit       sync;
    bit [3:0] din;
  } samp_t;

  samp_t       hist[$];
  int unsigned n_samp = 0;
  bit [3:0]    m_nibs[$];
  bit [15:0]   m_word = '0;
  bit          m_valid = 1'b0;
  bit          m_ovf = 1'b0;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned loads = 0;
  int unsigned vcycles = 0;
  bit          prev_v = 1'b0;
  bit [15:0]   last_word = '0;
  bit          rnd_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pins are sampled at every edge since reset; a value is used two edges after sampling.
  task automatic model_edge();
    samp_t    s;
    bit       ev, sy, old_v, loaded;
    bit [3:0] d;
    bit [15:0] w;
    if (!rst) begin
      hist.delete();
      n_samp = 0;
      m_nibs.delete();
      m_word = '0;
      m_valid = 1'b0;
      m_ovf = 1'b0;
      return;
    end
    s.stb = bus.stb; s.sync = bus.sync; s.din = bus.din;
    hist.push_back(s);
    n_samp++;
    if (hist.size() > 4) void'(hist.pop_front());
    ev = (n_samp >= 4) && hist[1].stb && !hist[0].stb;
    sy = (n_samp >= 3) && hist[hist.size()-3].sync;
    d  = (n_samp >= 3) ? hist[hist.size()-3].din : 4'h0;
    old_v = m_valid;
    loaded = 1'b0;
    if (sy) begin
      m_nibs.delete();
    end else if (ev) begin
      m_nibs.push_back(d);
      if (m_nibs.size() == 4) begin
        w = '0;
        foreach (m_nibs[i]) w = 16'(w * 16 + m_nibs[i]);
        m_nibs.delete();
        if (!old_v || bus.ready) begin
          m_word = w;
          m_valid = 1'b1;
          loaded = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (old_v && bus.ready && !loaded) m_valid = 1'b0;
  endtask

  task automatic step();
    if (rnd_mode) begin
      bus.ready = 1'($urandom_range(0, 1));
      bus.sync  = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk);
    model_edge();
    #1;
    check("word",  32'(bus.word),  32'(m_word));
    check("valid", 32'(bus.valid), 32'(m_valid));
    check("ovf",   32'(bus.ovf),   32'(m_ovf));
    check("cnt",   32'(bus.cnt),   32'(m_nibs.size()));
    if (bus.valid && !prev_v) begin
      loads++;
      last_word = bus.word;
    end
    if (bus.valid) vcycles++;
    prev_v = bus.valid;
  endtask

  task automatic send_nib(input bit [3:0] d, input bit pulse_ready);
    bus.din = d;
    step();
    bus.stb = 1'b1;
    step();
    step();
    if (pulse_ready) bus.ready = 1'b1;
    step();
    if (pulse_ready) bus.ready = 1'b0;
    bus.stb = 1'b0;
    step();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    repeat (4) step();
  endtask

  int unsigned l0, v0;

  initial begin
    bus.din = '0; bus.stb = 1'b0; bus.sync = 1'b0; bus.ready = 1'b0;
    repeat (3) step();
    check("rst_word", 32'(bus.word), 32'h0);
    check("rst_valid", 32'(bus.valid), 32'h0);
    rst = 1'b1;
    repeat (4) step();

    // Streamed word with READY high: one-cycle valid.
    bus.ready = 1'b1;
    l0 = loads; v0 = vcycles;
    send_nib(4'hA, 1'b0); check("cnt1", 32'(bus.cnt), 32'd1);
    send_nib(4'hB, 1'b0); check("cnt2", 32'(bus.cnt), 32'd2);
    send_nib(4'hC, 1'b0); check("cnt3", 32'(bus.cnt), 32'd3);
    send_nib(4'hD, 1'b0); check("cnt0", 32'(bus.cnt), 32'd0);
    check("abcd_word", 32'(last_word), 32'hABCD);
    check("abcd_loads", loads - l0, 32'd1);
    check("abcd_vcyc", vcycles - v0, 32'd1);
    check("abcd_ovf", 32'(bus.ovf), 32'h0);

    // Second word dropped while the first is held.
    bus.ready = 1'b0;
    for (int i = 1; i <= 8; i++) send_nib(4'(i), 1'b0);
    check("hold_word", 32'(bus.word), 32'h1234);
    check("hold_valid", 32'(bus.valid), 32'h1);
    check("hold_ovf", 32'(bus.ovf), 32'h1);
    bus.ready = 1'b1;
    step();
    check("drop_valid", 32'(bus.valid), 32'h0);
    bus.ready = 1'b0;

    // Resync mid-word.
    do_reset();
    send_nib(4'hF, 1'b0);
    send_nib(4'hE, 1'b0);
    bus.sync = 1'b1; repeat (2) step();
    bus.sync = 1'b0; repeat (3) step();
    check("sync_cnt", 32'(bus.cnt), 32'd0);
    send_nib(4'h9, 1'b0); send_nib(4'h8, 1'b0); send_nib(4'h7, 1'b0); send_nib(4'h6, 1'b0);
    check("sync_word", 32'(bus.word), 32'h9876);
    check("sync_ovf", 32'(bus.ovf), 32'h0);

    // SYNC held across an STB rise.
    bus.sync = 1'b1; repeat (2) step();
    send_nib(4'h5, 1'b0);
    check("sync_hold_cnt", 32'(bus.cnt), 32'd0);
    bus.sync = 1'b0; repeat (3) step();
    bus.ready = 1'b1; step(); bus.ready = 1'b0;

    // Reset mid-word with STB held high through release.
    send_nib(4'h3, 1'b0); send_nib(4'h4, 1'b0); send_nib(4'h5, 1'b0);
    bus.stb = 1'b1;
    rst = 1'b0; repeat (2) step();
    rst = 1'b1; repeat (5) step();
    check("rst_hi_cnt", 32'(bus.cnt), 32'd0);
    bus.stb = 1'b0; repeat (2) step();
    l0 = loads;
    send_nib(4'h0, 1'b0); send_nib(4'h0, 1'b0); send_nib(4'h0, 1'b0); send_nib(4'h1, 1'b0);
    check("rst_word1", 32'(bus.word), 32'h0001);
    check("rst_loads", loads - l0, 32'd1);

    // Fourth nibble coincides with the accept cycle.
    send_nib(4'h2, 1'b0); send_nib(4'h3, 1'b0); send_nib(4'h4, 1'b0);
    v0 = vcycles;
    send_nib(4'h5, 1'b1);
    check("b2b_word", 32'(bus.word), 32'h2345);
    check("b2b_valid", 32'(bus.valid), 32'h1);
    check("b2b_ovf", 32'(bus.ovf), 32'h0);
    check("b2b_nogap", vcycles - v0, 32'd6);

    // Random timing, READY and SYNC.
    rnd_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (n == 150) do_reset();
      bus.din = 4'($urandom);
      repeat ($urandom_range(1, 2)) step();
      bus.stb = 1'b1;
      repeat ($urandom_range(1, 4)) step();
      bus.stb = 1'b0;
      repeat ($urandom_range(1, 3)) step();
    end
    rnd_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
